// File: rtl/ir_playback_reader.sv
// ir_playback_reader: streams a stored impulse response out of the shared IR
// BRAM, one sample per audio tick, tracking IR availability and aborting when
// the recorder takes the BRAM back.
module ir_playback_reader #(
    parameter logic [15:0] IMPULSE_LENGTH = 16'd24000,
    parameter int unsigned READ_LATENCY   = 2
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    input  logic               audio_trigger,
    input  logic               impulse_recorded,
    input  logic               ir_write_busy,
    input  logic               start_playback,
    input  logic signed [15:0] read_data,
    output logic [15:0]        read_addr,
    output logic               read_enable,
    output logic signed [15:0] sample_out,
    output logic               sample_valid,
    output logic               playback_active,
    output logic               playback_done,
    output logic               ir_ready,
    output logic               overrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAMING = 2'd1,
        DRAIN     = 2'd2
    } state_t;

    localparam logic [15:0] LAST_INDEX = IMPULSE_LENGTH - 16'd1;

    state_t                  state;
    logic [15:0]             index;
    logic                    busy_q;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic                    capture;
    logic                    in_flight;
    logic                    abort;
    logic                    busy_rise;

    // rd_pipe[i] is high i+1 cycles after read_enable; the top tap marks the
    // cycle in which the BRAM presents the requested word on read_data.
    assign capture   = rd_pipe[READ_LATENCY-1];
    // A read occupies the window from read_enable up to (not including) the
    // cycle its sample_valid is shown, so a trigger coincident with
    // sample_valid is accepted.
    assign in_flight = read_enable | (|rd_pipe);
    assign abort     = ir_write_busy && (state != IDLE);
    assign busy_rise = ir_write_busy && !busy_q;

    // Read-latency tracker; an abort flushes it so no stale sample surfaces.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            rd_pipe <= '0;
        end else if (abort) begin
            rd_pipe <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage read the
            // previous cycle's value, which is what a shift register needs.
            rd_pipe[0] <= read_enable;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    // Playback FSM with IR bookkeeping and all registered outputs.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            state           <= IDLE;
            index           <= '0;
            busy_q          <= 1'b0;
            read_addr       <= '0;
            read_enable     <= 1'b0;
            sample_out      <= '0;
            sample_valid    <= 1'b0;
            playback_active <= 1'b0;
            playback_done   <= 1'b0;
            ir_ready        <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            busy_q        <= ir_write_busy;
            read_enable   <= 1'b0;
            sample_valid  <= 1'b0;
            playback_done <= 1'b0;

            // A fresh write clobbers the stored IR, even if it was just
            // reported complete in the same cycle.
            if (busy_rise) begin
                ir_ready <= 1'b0;
            end else if (impulse_recorded) begin
                ir_ready <= 1'b1;
            end

            if (audio_trigger && in_flight) begin
                overrun <= 1'b1;
            end

            if (capture && !abort) begin
                sample_out   <= read_data;
                sample_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_playback && ir_ready && !ir_write_busy) begin
                        index           <= '0;
                        state           <= STREAMING;
                        playback_active <= 1'b1;
                    end
                end
                STREAMING: begin
                    if (ir_write_busy) begin
                        state           <= IDLE;
                        playback_active <= 1'b0;
                    end else if (audio_trigger && !in_flight) begin
                        read_addr   <= index;
                        read_enable <= 1'b1;
                        if (index == LAST_INDEX) begin
                            state <= DRAIN;
                        end else begin
                            index <= index + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (ir_write_busy) begin
                        state           <= IDLE;
                        playback_active <= 1'b0;
                    end else if (sample_valid && !in_flight) begin
                        playback_done   <= 1'b1;
                        state           <= IDLE;
                        playback_active <= 1'b0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    playback_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_playback_reader.sv
// tb_ir_playback_reader: scoreboard bench for ir_playback_reader with an
// 8-sample IR and a two-cycle BRAM model holding data[i] = 100 + i.
module tb_ir_playback_reader;

    localparam logic [15:0] LEN = 16'd8;
    localparam int unsigned RL  = 2;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic               audio_clk = 1'b0;
    logic               rst_in    = 1'b1;
    logic               audio_trigger    = 1'b0;
    logic               impulse_recorded = 1'b0;
    logic               ir_write_busy    = 1'b0;
    logic               start_playback   = 1'b0;
    logic signed [15:0] read_data = '0;
    logic [15:0]        read_addr;
    logic               read_enable;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               playback_active;
    logic               playback_done;
    logic               ir_ready;
    logic               overrun;

    logic signed [15:0] bram_s1 = '0;
    int                 cyc = 0;
    int                 n_checks = 0;
    int                 n_errors = 0;

    exp_t addr_q[$];
    exp_t smp_q[$];
    exp_t done_q[$];

    ir_playback_reader #(
        .IMPULSE_LENGTH(LEN),
        .READ_LATENCY  (RL)
    ) dut (
        .audio_clk       (audio_clk),
        .rst_in          (rst_in),
        .audio_trigger   (audio_trigger),
        .impulse_recorded(impulse_recorded),
        .ir_write_busy   (ir_write_busy),
        .start_playback  (start_playback),
        .read_data       (read_data),
        .read_addr       (read_addr),
        .read_enable     (read_enable),
        .sample_out      (sample_out),
        .sample_valid    (sample_valid),
        .playback_active (playback_active),
        .playback_done   (playback_done),
        .ir_ready        (ir_ready),
        .overrun         (overrun)
    );

    always #5 audio_clk = ~audio_clk;

    always @(posedge audio_clk) cyc <= cyc + 1;

    // Two-stage BRAM model: word for read_addr appears two cycles after read_enable.
    always @(posedge audio_clk) begin
        if (read_enable) bram_s1 <= 16'(100 + int'(read_addr));
        read_data <= bram_s1;
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge audio_clk) begin
        exp_t e;
        if (!rst_in) begin
            if (read_enable) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_read_enable", read_enable, 0);
                end else begin
                    e = addr_q.pop_front();
                    check("read_addr", read_addr, e.val);
                    check("read_cycle", cyc, e.cyc);
                end
            end
            if (sample_valid) begin
                if (smp_q.size() == 0) begin
                    check("unexpected_sample_valid", sample_valid, 0);
                end else begin
                    e = smp_q.pop_front();
                    check("sample_out", sample_out, e.val);
                    check("sample_cycle", cyc, e.cyc);
                end
            end
            if (playback_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_playback_done", playback_done, 0);
                end else begin
                    e = done_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("active_with_done", playback_active, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge audio_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic trigger(input int addr, input bit exp_read, input bit exp_smp,
                           input bit last);
        audio_trigger = 1'b1;
        if (exp_read) addr_q.push_back(exp_t'{addr, cyc + 1});
        if (exp_smp) smp_q.push_back(exp_t'{100 + addr, cyc + 4});
        if (exp_smp && last) done_q.push_back(exp_t'{0, cyc + 5});
        tick();
        audio_trigger = 1'b0;
    endtask

    task automatic start();
        start_playback = 1'b1;
        tick();
        start_playback = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read_addr"}, read_addr, 0);
        check({tag, "_read_enable"}, read_enable, 0);
        check({tag, "_sample_out"}, sample_out, 0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_playback_active"}, playback_active, 0);
        check({tag, "_playback_done"}, playback_done, 0);
        check({tag, "_ir_ready"}, ir_ready, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset
        idle(3);
        check_reset_outputs("reset");
        rst_in = 1'b0;
        idle(2);

        // Start without a recorded IR
        start();
        check("noir_active", playback_active, 0);
        idle(2);
        trigger(0, 1'b0, 1'b0, 1'b0);
        idle(6);
        check("noir_active_late", playback_active, 0);

        // Normal playback
        impulse_recorded = 1'b1;
        tick();
        impulse_recorded = 1'b0;
        check("ir_ready_set", ir_ready, 1);
        start();
        check("normal_active", playback_active, 1);
        idle(2);
        for (int a = 0; a < 8; a++) begin
            trigger(a, 1'b1, 1'b1, a == 7);
            idle(9);
        end
        check("normal_active_end", playback_active, 0);
        check("normal_overrun", overrun, 0);
        check("normal_smp_q_empty", smp_q.size(), 0);
        check("normal_done_q_empty", done_q.size(), 0);

        // Writer abort after the third trigger
        start();
        check("abort_active", playback_active, 1);
        idle(2);
        trigger(0, 1'b1, 1'b1, 1'b0);
        idle(9);
        trigger(1, 1'b1, 1'b1, 1'b0);
        idle(9);
        trigger(2, 1'b1, 1'b0, 1'b0);
        ir_write_busy = 1'b1;
        idle(4);
        ir_write_busy = 1'b0;
        check("abort_ir_ready", ir_ready, 0);
        check("abort_active_end", playback_active, 0);
        idle(4);
        start();
        idle(2);
        check("abort_restart_active", playback_active, 0);
        trigger(0, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Recorded and start in the same cycle: start must be ignored
        impulse_recorded = 1'b1;
        start_playback   = 1'b1;
        tick();
        impulse_recorded = 1'b0;
        start_playback   = 1'b0;
        check("same_cycle_ir_ready", ir_ready, 1);
        check("same_cycle_active", playback_active, 0);
        idle(2);

        // Overrun: second trigger two cycles after the first is dropped
        start();
        idle(2);
        trigger(0, 1'b1, 1'b1, 1'b0);
        idle(1);
        trigger(0, 1'b0, 1'b0, 1'b0);
        check("overrun_set", overrun, 1);
        idle(8);
        for (int a = 1; a < 8; a++) begin
            trigger(a, 1'b1, 1'b1, a == 7);
            idle(9);
        end
        check("overrun_sticky", overrun, 1);
        check("overrun_active_end", playback_active, 0);
        check("overrun_smp_q_empty", smp_q.size(), 0);

        // Asynchronous reset one cycle before the last sample_valid
        start();
        idle(2);
        for (int a = 0; a < 7; a++) begin
            trigger(a, 1'b1, 1'b1, 1'b0);
            idle(9);
        end
        trigger(7, 1'b1, 1'b0, 1'b0);
        idle(2);
        #2 rst_in = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        idle(2);
        rst_in = 1'b0;
        idle(8);
        check("post_reset_ir_ready", ir_ready, 0);
        check("post_reset_active", playback_active, 0);
        start();
        idle(2);
        check("post_reset_start_ignored", playback_active, 0);

        check("final_addr_q_empty", addr_q.size(), 0);
        check("final_smp_q_empty", smp_q.size(), 0);
        check("final_done_q_empty", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ir_playback_reader.md
# ir_playback_reader

Reads a recorded impulse response back out of the shared IR sample BRAM, one sample per audio tick, and streams it to downstream convolution and monitoring logic. It is the read-side counterpart of the impulse recorder. It tracks when a complete IR is available, refuses or aborts playback while the recorder is writing, and absorbs the BRAM read latency with an in-flight pipeline.

## Interface
Parameters:
- IMPULSE_LENGTH, 16'd24000, number of IR samples per playback (addresses 0..IMPULSE_LENGTH-1)
- READ_LATENCY, 2, cycles from read_enable high to read_data valid; legal range 1..4

Ports:
- audio_clk  input  1  system clock; the design's only clock
- rst_in  input  1  reset; asynchronous, active-high
- audio_trigger  input  1  one-cycle pulse per audio sample period
- impulse_recorded  input  1  one-cycle pulse from the recorder: a complete IR is now in BRAM
- ir_write_busy  input  1  recorder write_enable; high while the recorder owns the BRAM
- start_playback  input  1  one-cycle request to play the stored IR
- read_data  input  signed 16  BRAM read port data
- read_addr  output  16  BRAM read address
- read_enable  output  1  BRAM read strobe, one cycle per sample
- sample_out  output  signed 16  played-back IR sample
- sample_valid  output  1  one-cycle qualifier for sample_out
- playback_active  output  1  high in STREAMING and DRAIN
- playback_done  output  1  one-cycle pulse on normal completion
- ir_ready  output  1  a complete, unclobbered IR is stored
- overrun  output  1  sticky: a trigger arrived while a read was still in flight

## Operation
- The flag ir_ready sets on impulse_recorded. It clears on a rising edge of ir_write_busy. If both occur in the same cycle, it clears.
- States are IDLE, STREAMING and DRAIN. Any illegal encoding returns to IDLE.
- IDLE:
  - On start_playback with ir_ready=1 and ir_write_busy=0: clear the index to 0 and go to STREAMING.
  - Otherwise start_playback is ignored.
- STREAMING:
  - On audio_trigger with no read in flight: drive read_addr=index and read_enable=1 for one cycle, then increment the index.
  - After issuing address IMPULSE_LENGTH-1, go to DRAIN.
- DRAIN: when the last in-flight read returns, pulse playback_done and go to IDLE.
- Read data path:
  - read_data is captured READ_LATENCY cycles after read_enable.
  - It is registered onto sample_out with sample_valid=1.
  - sample_out holds its value between valids.
- In-flight rule:
  - A read is in flight from read_enable until its sample_valid.
  - An audio_trigger during that window is dropped (no address advance) and sets overrun.
  - overrun clears only on reset.
- Abort: ir_write_busy=1 in STREAMING or DRAIN aborts playback.
  - Go to IDLE and kill any pending sample_valid.
  - Do not pulse playback_done.
  - ir_ready clears per the rule above.
- start_playback in STREAMING or DRAIN is ignored; there is no restart.
- Index arithmetic is 16-bit unsigned. The index never exceeds IMPULSE_LENGTH-1 and does not wrap.

## Timing
- Reset values: read_addr=0, read_enable=0, sample_out=0, sample_valid=0, playback_active=0, playback_done=0, ir_ready=0, overrun=0, state=IDLE, index=0.
- Reset mid-playback asserts outputs to reset values immediately (asynchronous). Nothing is retained.
- start_playback accepted in cycle S gives playback_active=1 from cycle S+1.
- audio_trigger in cycle T gives read_enable=1 and read_addr valid in cycle T+1.
- read_data is sampled in cycle T+1+READ_LATENCY.
- sample_valid=1 in cycle T+2+READ_LATENCY. With the default, trigger to sample latency is 4 cycles.
- playback_done pulses in the cycle after the last sample_valid. playback_active drops in that same cycle.
- The minimum trigger spacing without overrun is READ_LATENCY+2 cycles.
- impulse_recorded and start_playback in the same cycle: the start is ignored, because ir_ready is not yet set.

## Test plan
- Reset: assert rst_in asynchronously mid-cycle -> all outputs 0 before the next edge. Deassert -> state IDLE.
- Normal playback: IMPULSE_LENGTH=8, BRAM model with READ_LATENCY=2 and data[i]=100+i. Pulse impulse_recorded, then start, then triggers every 10 cycles ->
  - read_addr 0..7
  - sample_out 100..107, each valid 4 cycles after its trigger
  - playback_done exactly once, one cycle after sample 107
  - no overrun
- Start without IR: start_playback after reset only -> no read_enable, playback_active stays 0.
- Writer abort: ir_write_busy raised after the 3rd trigger -> no sample_valid for the in-flight read, no playback_done, ir_ready=0, state IDLE. A later start is ignored until impulse_recorded.
- Overrun: triggers 2 cycles apart -> second trigger dropped, read_addr does not advance, overrun=1 and stays 1 through completion. Playback still yields all 8 samples given later slow triggers.
- Reset mid-DRAIN: reset asserted one cycle before the last sample_valid -> no sample_valid, no playback_done, ir_ready=0.
